// File: rtl/lcd_write_arbiter_pkg.sv
// Shared types and constants for the LCD character-write arbiter.
// No logic of its own; purely declarations.
// No flow control; consumers apply their own handshakes.
package lcd_arb_pkg;

   // Sequencer states: waiting for work, or holding off after a strobe
   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   // Which source produced the most recent strobe
   typedef enum logic {
      KB  = 1'b0,
      MSG = 1'b1
   } src_t;

   localparam int         MSG_CHARS_DEFAULT = 16;
   localparam logic [7:0] ASCII_NUL         = 8'h00;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Bundle of keyboard, message and LCD character-port signals around the arbiter.
// Wires only, zero latency.
// Messages use valid/ready; keyboard and LCD strobes are unacknowledged pulses.
interface lcd_write_arbiter_if
   import lcd_arb_pkg::*;
#(
   parameter int MSG_CHARS = MSG_CHARS_DEFAULT
);

   logic                   kb_valid;
   logic [7:0]             kb_char;
   logic                   msg_valid;
   logic [8*MSG_CHARS-1:0] msg_data;
   logic                   msg_ready;
   logic                   msg_done;
   logic                   lcd_strobe;
   logic [7:0]             lcd_char;
   logic                   kb_overflow;
   logic                   busy;

   // Upstream side: character sources plus whoever watches the LCD port
   modport master (
      output kb_valid, kb_char, msg_valid, msg_data,
      input  msg_ready, msg_done, lcd_strobe, lcd_char, kb_overflow, busy
   );

   // Arbiter side
   modport slave (
      input  kb_valid, kb_char, msg_valid, msg_data,
      output msg_ready, msg_done, lcd_strobe, lcd_char, kb_overflow, busy
   );

endinterface

// File: rtl/lcd_write_arbiter_kb_char_buffer.sv
// One-entry holding register for keyboard characters with sticky overflow flag.
// Character is visible on kb_buf/kb_full one cycle after kb_valid.
// No backpressure: a key arriving while full and not consumed is dropped and flagged.
module kb_char_buffer
   import lcd_arb_pkg::*;
(
   input  logic       clock,
   input  logic       RESETN,
   input  logic       kb_valid,
   input  logic [7:0] kb_char,
   input  logic       consume,
   output logic       kb_full,
   output logic [7:0] kb_buf,
   output logic       kb_overflow
);

   logic [7:0] kb_buf_q, kb_buf_d;
   logic       kb_full_q, kb_full_d;
   logic       kb_overflow_q, kb_overflow_d;

   // Write when empty or when the held character leaves this cycle; otherwise drop
   always_comb begin
      kb_buf_d      = kb_buf_q;
      kb_full_d     = kb_full_q;
      kb_overflow_d = kb_overflow_q;
      if (consume) begin
         kb_full_d = 1'b0;
      end
      if (kb_valid) begin
         if (!kb_full_q || consume) begin
            kb_buf_d  = kb_char;
            kb_full_d = 1'b1;
         end else begin
            kb_overflow_d = 1'b1;
         end
      end
   end

   // Buffer registers, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!RESETN) begin
         kb_buf_q      <= ASCII_NUL;
         kb_full_q     <= 1'b0;
         kb_overflow_q <= 1'b0;
      end else begin
         kb_buf_q      <= kb_buf_d;
         kb_full_q     <= kb_full_d;
         kb_overflow_q <= kb_overflow_d;
      end
   end

   assign kb_full     = kb_full_q;
   assign kb_buf      = kb_buf_q;
   assign kb_overflow = kb_overflow_q;

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD character-write port between keyboard keys and fixed-length messages.
// Key or message accept in cycle N gives the first lcd_strobe in N+2; strobes spaced CHAR_GAP+.
// msg_ready drops while a message is latched; keys queue in one slot and overflow when it is full.
module lcd_write_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int CHAR_GAP  = 16,
   parameter int MSG_CHARS = MSG_CHARS_DEFAULT
) (
   input logic                clock,
   input logic                RESETN,
   lcd_write_arbiter_if.slave bus
);

   localparam int MSG_W = 8 * MSG_CHARS;
   localparam int GAP_W = $clog2(CHAR_GAP + 1);
   localparam int IDX_W = $clog2(MSG_CHARS + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHAR_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(MSG_CHARS);

   state_t             state_q, state_d;
   src_t               src_q, src_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [MSG_W-1:0]   msg_sr_q, msg_sr_d;
   logic               msg_busy_q, msg_busy_d;
   logic               lcd_strobe_q, lcd_strobe_d;
   logic [7:0]         lcd_char_q, lcd_char_d;
   logic               msg_done_q, msg_done_d;

   logic               kb_consume;
   logic               kb_full;
   logic [7:0]         kb_buf;
   logic               kb_overflow;
   logic               msg_step;
   logic [7:0]         msg_byte;
   logic               msg_end;

   kb_char_buffer u_kb_buf (
      .clock       (clock),
      .RESETN      (RESETN),
      .kb_valid    (bus.kb_valid),
      .kb_char     (bus.kb_char),
      .consume     (kb_consume),
      .kb_full     (kb_full),
      .kb_buf      (kb_buf),
      .kb_overflow (kb_overflow)
   );

   // Next message byte sits in the top of the shift register; null or count exhaustion ends it
   assign msg_byte = msg_sr_q[MSG_W-1 -: 8];
   assign msg_end  = (msg_byte == ASCII_NUL) || (idx_q == IDX_END);

   // Sequencer: message latch, keyboard-first arbitration before a message starts, gap timing
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      gap_cnt_d    = gap_cnt_q;
      idx_d        = idx_q;
      msg_sr_d     = msg_sr_q;
      msg_busy_d   = msg_busy_q;
      lcd_strobe_d = 1'b0;
      lcd_char_d   = lcd_char_q;
      msg_done_d   = 1'b0;
      kb_consume   = 1'b0;
      msg_step     = 1'b0;

      // Accept only while no message is held, so this never collides with a message step
      if (bus.msg_valid && !msg_busy_q) begin
         msg_sr_d   = bus.msg_data;
         idx_d      = '0;
         msg_busy_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            // idx of zero means no byte of a held message has gone out yet
            if (kb_full && idx_q == '0) begin
               lcd_strobe_d = 1'b1;
               lcd_char_d   = kb_buf;
               kb_consume   = 1'b1;
               src_d        = KB;
               gap_cnt_d    = GAP_RELOAD;
               state_d      = GAP;
            end else if (msg_busy_q) begin
               msg_step = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q != '0) begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end else if (src_q == MSG) begin
               // Chain message bytes back-to-back so spacing is exactly CHAR_GAP
               msg_step = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase

      if (msg_step) begin
         if (msg_end) begin
            msg_done_d = 1'b1;
            msg_busy_d = 1'b0;
            idx_d      = '0;
            state_d    = IDLE;
         end else begin
            lcd_strobe_d = 1'b1;
            lcd_char_d   = msg_byte;
            msg_sr_d     = msg_sr_q << 8;
            idx_d        = idx_q + 1'b1;
            src_d        = MSG;
            gap_cnt_d    = GAP_RELOAD;
            state_d      = GAP;
         end
      end
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!RESETN) begin
         state_q      <= IDLE;
         src_q        <= KB;
         gap_cnt_q    <= '0;
         idx_q        <= '0;
         msg_sr_q     <= '0;
         msg_busy_q   <= 1'b0;
         lcd_strobe_q <= 1'b0;
         lcd_char_q   <= ASCII_NUL;
         msg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         gap_cnt_q    <= gap_cnt_d;
         idx_q        <= idx_d;
         msg_sr_q     <= msg_sr_d;
         msg_busy_q   <= msg_busy_d;
         lcd_strobe_q <= lcd_strobe_d;
         lcd_char_q   <= lcd_char_d;
         msg_done_q   <= msg_done_d;
      end
   end

   assign bus.msg_ready   = !msg_busy_q;
   assign bus.msg_done    = msg_done_q;
   assign bus.lcd_strobe  = lcd_strobe_q;
   assign bus.lcd_char    = lcd_char_q;
   assign bus.kb_overflow = kb_overflow;
   assign bus.busy        = (state_q != IDLE) || msg_busy_q || kb_full;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: directed scenarios with randomized payloads.
// Expected strobe/done timelines come from arithmetic on the accept/press cycles.
// Drives inputs 1 time unit after the rising edge; samples outputs after the falling edge.
module tb_lcd_write_arbiter;
   import lcd_arb_pkg::*;

   localparam int CG = 16;
   localparam int MC = MSG_CHARS_DEFAULT;

   logic clock  = 1'b0;
   logic RESETN = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   lcd_write_arbiter_if #(.MSG_CHARS(MC)) bus ();

   lcd_write_arbiter #(.CHAR_GAP(CG), .MSG_CHARS(MC)) dut (
      .clock  (clock),
      .RESETN (RESETN),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Observed events, recorded with the cycle in which they are visible
   int         obs_cyc[$];
   logic [7:0] obs_chr[$];
   int         obs_done[$];
   // Expected events from the reference timeline
   int         exp_cyc[$];
   logic [7:0] exp_chr[$];
   int         exp_done[$];

   always @(negedge clock) begin
      if (bus.lcd_strobe === 1'b1) begin
         obs_cyc.push_back(cyc);
         obs_chr.push_back(bus.lcd_char);
      end
      if (bus.msg_done === 1'b1) obs_done.push_back(cyc);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Park just after the falling edge of cycle c
   task automatic goto(input int c);
      forever begin
         @(negedge clock);
         if (cyc >= c) break;
      end
      #1;
   endtask

   task automatic kb_press(input logic [7:0] c, output int n);
      @(posedge clock); #1;
      bus.kb_valid = 1'b1;
      bus.kb_char  = c;
      n = cyc;
      @(posedge clock); #1;
      bus.kb_valid = 1'b0;
   endtask

   task automatic msg_offer(input logic [8*MC-1:0] m, output int a);
      int waited;
      waited = 0;
      a = -1;
      @(posedge clock); #1;
      bus.msg_valid = 1'b1;
      bus.msg_data  = m;
      while (a < 0 && waited < 2000) begin
         if (bus.msg_ready === 1'b1) a = cyc;
         else begin
            @(posedge clock); #1;
            waited++;
         end
      end
      if (a < 0) begin
         check("msg accept timeout", bus.msg_ready, 1);
         a = cyc;
      end
      @(posedge clock); #1;
      bus.msg_valid = 1'b0;
   endtask

   function automatic logic [7:0] byte_of(input logic [8*MC-1:0] m, input int k);
      return m[8*(MC-1-k) +: 8];
   endfunction

   // Printable bytes everywhere; a null at position cut (if cut < MC) with garbage after it
   function automatic logic [8*MC-1:0] rand_msg(input int cut);
      logic [8*MC-1:0] m;
      for (int k = 0; k < MC; k++)
         m[8*(MC-1-k) +: 8] = (k == cut) ? 8'h00 : 8'($urandom_range(33, 126));
      return m;
   endfunction

   // First byte strobes at 'first'; one byte per CG cycles until null or MC bytes; done one gap later
   task automatic model_msg(input int first, input logic [8*MC-1:0] m, output int done_cyc);
      int n;
      n = MC;
      for (int k = MC - 1; k >= 0; k--)
         if (byte_of(m, k) == 8'h00) n = k;
      for (int k = 0; k < n; k++) begin
         exp_cyc.push_back(first + k * CG);
         exp_chr.push_back(byte_of(m, k));
      end
      done_cyc = first + n * CG;
      exp_done.push_back(done_cyc);
   endtask

   task automatic verify(input string tag);
      check($sformatf("%s strobe count", tag), obs_cyc.size(), exp_cyc.size());
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         check($sformatf("%s strobe%0d cycle", tag, i), obs_cyc[i], exp_cyc[i]);
         check($sformatf("%s strobe%0d char", tag, i), obs_chr[i], exp_chr[i]);
      end
      check($sformatf("%s done count", tag), obs_done.size(), exp_done.size());
      for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++)
         check($sformatf("%s done%0d cycle", tag, i), obs_done[i], exp_done[i]);
      obs_cyc.delete(); obs_chr.delete(); obs_done.delete();
      exp_cyc.delete(); exp_chr.delete(); exp_done.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check($sformatf("%s lcd_strobe", tag), bus.lcd_strobe, 0);
      check($sformatf("%s lcd_char", tag), bus.lcd_char, 8'h00);
      check($sformatf("%s msg_done", tag), bus.msg_done, 0);
      check($sformatf("%s kb_overflow", tag), bus.kb_overflow, 0);
      check($sformatf("%s busy", tag), bus.busy, 0);
      check($sformatf("%s msg_ready", tag), bus.msg_ready, 1);
   endtask

   initial begin
      int n, n2, a, d, t, s5, r, k;
      logic [7:0] c1, c2, c3;
      logic [8*MC-1:0] m;
      logic [8*MC-1:0] msgs[6];

      bus.kb_valid  = 1'b0;
      bus.kb_char   = 8'h00;
      bus.msg_valid = 1'b0;
      bus.msg_data  = '0;

      // Reset state
      goto(2);
      check_reset_values("reset");
      @(posedge clock); #1;
      RESETN = 1'b1;

      // Single key: press in cycle 5, strobe in cycle 7, busy falls at 7+CG
      goto(4);
      kb_press(8'h61, n);
      exp_cyc.push_back(n + 2); exp_chr.push_back(8'h61);
      goto(n + 1);
      check("kb busy while buffered", bus.busy, 1);
      goto(n + 2 + CG - 1);
      check("kb busy end of gap", bus.busy, 1);
      goto(n + 2 + CG);
      check("kb busy after gap", bus.busy, 0);
      goto(n + 2 + CG + 2);
      verify("kb single");

      // Random isolated keys
      for (int i = 0; i < 4; i++) begin
         t = cyc + 1 + int'($urandom_range(0, 5));
         goto(t);
         c1 = 8'($urandom_range(33, 126));
         kb_press(c1, n);
         exp_cyc.push_back(n + 2); exp_chr.push_back(c1);
         goto(n + 2 + CG + 1);
      end
      verify("kb random");

      // Messages: full, early null, all-zero, random
      msgs[0] = "hello world!    ";
      msgs[1] = {"hi", 112'h0};
      msgs[2] = '0;
      msgs[3] = rand_msg(int'($urandom_range(1, MC - 1)));
      msgs[4] = rand_msg(int'($urandom_range(1, MC - 1)));
      msgs[5] = rand_msg(MC);
      for (int i = 0; i < 6; i++) begin
         msg_offer(msgs[i], a);
         model_msg(a + 2, msgs[i], d);
         goto(a + 1);
         check($sformatf("msg%0d ready low", i), bus.msg_ready, 0);
         goto(d);
         check($sformatf("msg%0d ready at done", i), bus.msg_ready, 1);
         goto(d + 2);
         verify($sformatf("msg%0d", i));
      end

      // Key and message in the same cycle: key first, message follows after CG+1
      m = rand_msg(MC);
      @(posedge clock); #1;
      a = cyc;
      bus.kb_valid  = 1'b1; bus.kb_char  = 8'h7A;
      bus.msg_valid = 1'b1; bus.msg_data = m;
      @(posedge clock); #1;
      bus.kb_valid  = 1'b0;
      bus.msg_valid = 1'b0;
      exp_cyc.push_back(a + 2); exp_chr.push_back(8'h7A);
      model_msg(a + 3 + CG, m, d);
      goto(d + 2);
      verify("simultaneous");

      // Keys during a message: first waits until done, second is dropped
      m = rand_msg(MC);
      msg_offer(m, a);
      model_msg(a + 2, m, d);
      goto(a + 2 + 2 * CG + 2);
      c1 = 8'($urandom_range(33, 126));
      c2 = 8'($urandom_range(33, 126));
      kb_press(c1, n);
      goto(n + 3);
      check("overflow before drop", bus.kb_overflow, 0);
      kb_press(c2, n2);
      goto(n2 + 2);
      check("overflow after drop", bus.kb_overflow, 1);
      exp_cyc.push_back(d + 1); exp_chr.push_back(c1);
      goto(d + 1 + CG + 2);
      verify("kb during msg");

      // Reset in the cycle that would launch the 6th strobe
      m = rand_msg(MC);
      msg_offer(m, a);
      s5 = a + 2 + 4 * CG;
      for (int i = 0; i < 5; i++) begin
         exp_cyc.push_back(a + 2 + i * CG);
         exp_chr.push_back(byte_of(m, i));
      end
      goto(s5 + CG - 2);
      @(posedge clock); #1;
      RESETN = 1'b0;
      r = cyc;
      @(posedge clock); #1;
      RESETN = 1'b1;
      goto(r + 1);
      check_reset_values("mid-msg reset");
      goto(r + 1 + 3 * CG);
      verify("mid-msg reset");

      // Key burst on consecutive cycles: second rides the consume, third overflows
      c1 = 8'($urandom_range(33, 126));
      c2 = 8'($urandom_range(33, 126));
      c3 = 8'($urandom_range(33, 126));
      @(posedge clock); #1;
      k = cyc;
      bus.kb_valid = 1'b1; bus.kb_char = c1;
      @(posedge clock); #1;
      bus.kb_char = c2;
      @(posedge clock); #1;
      bus.kb_char = c3;
      @(posedge clock); #1;
      bus.kb_valid = 1'b0;
      exp_cyc.push_back(k + 2);      exp_chr.push_back(c1);
      exp_cyc.push_back(k + 3 + CG); exp_chr.push_back(c2);
      goto(k + 3);
      check("burst overflow", bus.kb_overflow, 1);
      goto(k + 3 + 2 * CG + 2);
      check("burst idle busy", bus.busy, 0);
      verify("kb burst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

- Shares the single character-write port of the `lcd` driver between two sources:
  - keyboard characters (one ASCII byte per key press);
  - 16-character ASCII messages delivered by `gpio_protocol`.
- Sequences message bytes one per strobe and enforces a minimum strobe spacing so the LCD driver can consume each character.
- Sits in `skeleton` between the PS/2 ASCII decode / GPIO receive path and `lcd`.

## Interface
Parameters:
- `CHAR_GAP`, default 16: cycles between consecutive `lcd_strobe` pulses; must be ≥ 1.
- `MSG_CHARS`, default 16: characters per message. `msg_data` is `8*MSG_CHARS` bits.

Ports:
- `clock` in 1: single clock for all logic.
- `RESETN` in 1: synchronous, active-low reset.
- `kb_valid` in 1: one-cycle pulse; `kb_char` is valid this cycle.
- `kb_char` in 8: keyboard ASCII byte.
- `msg_valid` in 1: a message is offered.
- `msg_data` in 128: message; byte 0 is `[127:120]` and is displayed first.
- `msg_ready` out 1: message accepted when `msg_valid & msg_ready`.
- `msg_done` out 1: one-cycle pulse when a message finishes.
- `lcd_strobe` out 1: one-cycle write pulse to `lcd`.
- `lcd_char` out 8: character for `lcd`; held between strobes.
- `kb_overflow` out 1: sticky; a keyboard character was dropped.
- `busy` out 1: high when `state≠IDLE` or `msg_busy` or `kb_full`.

## Operation
Keyboard buffer:
- One-entry buffer `kb_buf`, with flag `kb_full`.
- `kb_valid` while empty, or in the same cycle the buffer is consumed: the character is written and `kb_full`=1.
- `kb_valid` while full and not being consumed: the character is dropped and `kb_overflow`←1.

Message latch:
- `msg_ready` = `!msg_busy`.
- On accept: `msg_data` is latched into a shift register, `idx`←0, `msg_busy`←1.

States:
- **IDLE**
  - If `kb_full` and `idx`=0: emit `kb_buf`, clear `kb_full`, set `src`=KB, go to GAP.
  - Else if `msg_busy`: the next byte is "end" when it is 8'h00 or `idx`=MSG_CHARS.
    - If end: pulse `msg_done`, clear `msg_busy`, stay in IDLE.
    - Otherwise: emit the byte, `idx`++, set `src`=MSG, go to GAP.
- **GAP**
  - `gap_cnt` decrements each cycle.
  - When `gap_cnt`=0 and `src`=MSG: apply the message step above directly (emit and stay in GAP, or on end pulse `msg_done` and go to IDLE).
  - When `gap_cnt`=0 and `src`=KB: go to IDLE.

Emit:
- Registered: `lcd_strobe`←1, `lcd_char`←byte, `gap_cnt`←CHAR_GAP-1.
- `lcd_strobe` returns to 0 the following cycle.

Arbitration rules:
- A message is atomic once its first byte is emitted; keyboard characters wait in `kb_buf`.
- Keyboard wins only while no message byte has been emitted.
- Null byte: ends the message early; no strobe is issued for the null or any later byte.
- An all-zero message produces `msg_done` with zero strobes.

## Timing
Reset values, applied at the first clock edge with `RESETN`=0:
- `lcd_strobe`=0, `lcd_char`=8'h00, `msg_done`=0, `kb_overflow`=0, `busy`=0, `msg_ready`=1.
- State IDLE; buffer and latch cleared.

Reset mid-message:
- Remaining characters are discarded and no `msg_done` is issued.
- A strobe pending for the next edge is suppressed.

Latency and spacing:
- Keyboard: `kb_valid` in cycle N with IDLE and empty buffer → `lcd_strobe` in cycle N+2.
- Strobe spacing within a message: exactly CHAR_GAP cycles.
- Keyboard strobe followed by another keyboard strobe: at least CHAR_GAP+1 cycles apart.
- Message: accept in cycle N (IDLE, no keyboard character) → first strobe in cycle N+2.

`msg_done`:
- Pulses one cycle; it is registered at the same edge that clears `msg_busy`.
- `msg_ready` is therefore already 1 in the `msg_done` cycle.
- A new message may be accepted that cycle.

Simultaneous events:
- `kb_valid` in the same cycle as a message accept: both are captured; the keyboard character is emitted first.

## Structure
Package `lcd_arb_pkg` holds:
- the state enum {IDLE, GAP};
- the source enum {KB, MSG};
- `MSG_CHARS_DEFAULT`=16;
- `ASCII_NUL`=8'h00.

Sub-module `kb_char_buffer`: the one-entry holding register with consume input and sticky overflow flag.

The counter is `$clog2(CHAR_GAP+1)` bits wide.

## Test plan
1. **Keyboard character:** reset, then `kb_valid` with 8'h61 in cycle 5 → `lcd_strobe`=1 with `lcd_char`=8'h61 in cycle 7; `busy` stays high until cycle 7+CHAR_GAP.
2. **Full message:** offer "hello world!    " (16 bytes) → 16 strobes spaced exactly 16 cycles apart, in order 'h','e',…; `msg_done` in the cycle after the last gap; `msg_ready`=0 throughout.
3. **Early termination:** message "hi" followed by 14 null bytes → 2 strobes, then `msg_done`; an all-zero message → `msg_done` two cycles after accept with no strobe.
4. **Keyboard during a message:** press 'a' after the 3rd message strobe, then 'b' → 'a' is emitted after message byte 15; 'b' is dropped and `kb_overflow`=1.
5. **Simultaneous arrival:** `kb_valid`(8'h7A) together with a message accept in the same IDLE cycle → 'z' is strobed first, followed by the full message.
6. **Reset mid-message:** `RESETN`=0 after the 5th strobe → all outputs at reset values next edge, no `msg_done`, `msg_ready`=1, and no further strobes.
